hazard_forward_ctrl: RTL and testbench

Parametrised hazard and forwarding controller for the 5-stage pipelined CPU. It replaces the purely combinational forwarding unit with a block that tracks its own destination-tag pipeline across the EX, MEM and WB stages. It generates per-operand forwarding selects for the instruction in EX and a load-use stall/bubble for the instruction in ID. It honours external pipeline freeze and flush, and keeps saturating hazard performance counters. It sits beside the ID/EX pipeline register, with its selects driving the EX-stage operand muxes.

---
 rtl/hazard_pkg.sv | 19 +
 rtl/hazard_tag_stage.sv | 34 +++
 rtl/hazard_forward_ctrl.sv | 167 ++++++++++++++++
 tb/tb_hazard_forward_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings and tag layout for the hazard/forwarding controller.
package hazard_pkg;

    // EX-stage operand mux selects
    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_MEMWB   = 2'b01;
    localparam logic [1:0] FWD_EXMEM   = 2'b10;

    localparam int DEF_REG_ADDR_W = 4;

    // Reference layout of one destination tag at the default address width.
    typedef struct packed {
        logic                      valid;
        logic [DEF_REG_ADDR_W-1:0] dst;
        logic                      reg_write;
        logic                      is_load;
    } tag_t;

endpackage

// File: rtl/hazard_tag_stage.sv
// One pipeline tag register: holds on !en, inserts an all-zero bubble when
// bubble is set, otherwise captures the upstream tag.
module hazard_tag_stage
    import hazard_pkg::*;
#(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         bubble,
    input  logic         d_valid,
    input  logic [W-1:0] d,
    output logic         q_valid,
    output logic [W-1:0] q
);

    // Tag register with async clear, load enable and bubble insert
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_valid <= 1'b0;
            q       <= '0;
        end else if (en) begin
            if (bubble) begin
                q_valid <= 1'b0;
                q       <= '0;
            end else begin
                q_valid <= d_valid;
                q       <= d;
            end
        end
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard and forwarding controller: tracks destination tags through EX, MEM
// and WB, drives EX operand forwarding selects, detects load-use hazards for
// the ID instruction and keeps saturating hazard counters.
module hazard_forward_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W  = 4,
    parameter int NUM_SRC     = 2,
    parameter int CNT_W       = 16,
    parameter bit ZERO_REG_EN = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          id_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
    input  logic [NUM_SRC-1:0]            id_src_used,
    input  logic [REG_ADDR_W-1:0]         id_dst,
    input  logic                          id_reg_write,
    input  logic                          id_is_load,
    input  logic                          ext_stall,
    input  logic                          flush,
    input  logic                          clr_cnt,
    output logic                          stall_id,
    output logic                          bubble_ex,
    output logic [NUM_SRC*2-1:0]          fwd_sel,
    output logic [CNT_W-1:0]              stall_cnt,
    output logic [CNT_W-1:0]              fwd_cnt
);

    // MEM payload: {dst, reg_write, is_load}
    localparam int TW  = REG_ADDR_W + 2;
    // EX payload adds the source fields: {src, src_used, dst, reg_write, is_load}
    localparam int EXW = NUM_SRC*REG_ADDR_W + NUM_SRC + TW;
    // WB payload drops is_load: nothing past MEM cares whether it was a load
    localparam int WBW = REG_ADDR_W + 1;

    logic                          advance;
    logic                          ex_take_id;
    logic                          ex_bubble;
    logic [EXW-1:0]                id_tag;

    logic                          ex_valid;
    logic [EXW-1:0]                ex_q;
    logic [NUM_SRC*REG_ADDR_W-1:0] ex_src;
    logic [NUM_SRC-1:0]            ex_used;
    logic [REG_ADDR_W-1:0]         ex_dst;
    logic                          ex_rw;
    logic                          ex_ld;
    logic                          ex_wc;

    logic                          mem_valid;
    logic [TW-1:0]                 mem_q;
    logic [REG_ADDR_W-1:0]         mem_dst;
    logic                          mem_rw;
    logic                          mem_ld;
    logic                          mem_wc;

    logic                          wb_valid;
    logic [WBW-1:0]                wb_d;
    logic [WBW-1:0]                wb_q;
    logic [REG_ADDR_W-1:0]         wb_dst;
    logic                          wb_rw;
    logic                          wb_wc;

    logic [NUM_SRC-1:0]            lu_hit;
    logic [NUM_SRC-1:0]            mem_hit;
    logic [NUM_SRC-1:0]            wb_hit;

    assign advance    = !ext_stall;
    assign ex_take_id = id_valid && !stall_id && !flush;
    assign ex_bubble  = !ex_take_id;
    assign id_tag     = {id_src, id_src_used, id_dst, id_reg_write, id_is_load};

    hazard_tag_stage #(.W(EXW)) u_ex (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (advance),
        .bubble  (ex_bubble),
        .d_valid (id_valid),
        .d       (id_tag),
        .q_valid (ex_valid),
        .q       (ex_q)
    );

    hazard_tag_stage #(.W(TW)) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (advance),
        .bubble  (1'b0),
        .d_valid (ex_valid),
        .d       (ex_q[TW-1:0]),
        .q_valid (mem_valid),
        .q       (mem_q)
    );

    assign wb_d = mem_q[TW-1:1];

    hazard_tag_stage #(.W(WBW)) u_wb (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (advance),
        .bubble  (1'b0),
        .d_valid (mem_valid),
        .d       (wb_d),
        .q_valid (wb_valid),
        .q       (wb_q)
    );

    assign ex_src  = ex_q[EXW-1 -: NUM_SRC*REG_ADDR_W];
    assign ex_used = ex_q[TW +: NUM_SRC];
    assign ex_dst  = ex_q[2 +: REG_ADDR_W];
    assign ex_rw   = ex_q[1];
    assign ex_ld   = ex_q[0];

    assign mem_dst = mem_q[2 +: REG_ADDR_W];
    assign mem_rw  = mem_q[1];
    assign mem_ld  = mem_q[0];

    assign wb_dst  = wb_q[1 +: REG_ADDR_W];
    assign wb_rw   = wb_q[0];

    // A tag can feed a consumer only if it really writes a non-hardwired register
    assign ex_wc  = ex_valid  && ex_rw  && !(ZERO_REG_EN && (ex_dst  == '0));
    assign mem_wc = mem_valid && mem_rw && !(ZERO_REG_EN && (mem_dst == '0));
    assign wb_wc  = wb_valid  && wb_rw  && !(ZERO_REG_EN && (wb_dst  == '0));

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_opnd
        logic [REG_ADDR_W-1:0] id_s;
        logic [REG_ADDR_W-1:0] ex_s;

        assign id_s = id_src[i*REG_ADDR_W +: REG_ADDR_W];
        assign ex_s = ex_src[i*REG_ADDR_W +: REG_ADDR_W];

        assign lu_hit[i]  = id_src_used[i] && ex_wc && ex_ld && (ex_dst == id_s);
        assign mem_hit[i] = ex_used[i] && mem_wc && (mem_dst == ex_s);
        assign wb_hit[i]  = ex_used[i] && wb_wc  && (wb_dst  == ex_s);

        // Youngest producer wins; an empty EX slot never forwards
        assign fwd_sel[2*i +: 2] = !ex_valid  ? FWD_REGFILE :
                                   mem_hit[i] ? FWD_EXMEM   :
                                   wb_hit[i]  ? FWD_MEMWB   : FWD_REGFILE;
    end

    assign stall_id  = !flush && id_valid && (|lu_hit);
    assign bubble_ex = stall_id || flush;

    // A load still in MEM cannot have a dependent in EX: the stall kept it in ID
    a_no_mem_load_fwd : assert property (@(posedge clk) disable iff (!rst_n)
        !(ex_valid && mem_ld && (|mem_hit)));

    // Saturating hazard counters, frozen while the pipeline is held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else if (clr_cnt) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (stall_id && advance && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (advance && ex_valid && (|fwd_sel) && (fwd_cnt != '1))
                fwd_cnt <= fwd_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: two instances (zero register hardwired and
// not) share one stimulus stream; a behavioural tag-pipeline model pushes
// expected outputs to a scoreboard queue that is popped against the DUTs.
module tb_hazard_forward_ctrl;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [3:0] s0, s1;
    logic [1:0] id_used;
    logic [3:0] id_dst;
    logic       id_rw, id_ld;
    logic       ext_stall, flush, clr_cnt;

    logic       st_o [2];
    logic       bb_o [2];
    logic [3:0] fw_o [2];
    logic [3:0] sc_o [2];
    logic [3:0] fc_o [2];

    int n_tests = 0;
    int n_fail  = 0;

    hazard_forward_ctrl #(.REG_ADDR_W(4), .NUM_SRC(2), .CNT_W(4), .ZERO_REG_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src({s1, s0}),
        .id_src_used(id_used), .id_dst(id_dst), .id_reg_write(id_rw), .id_is_load(id_ld),
        .ext_stall(ext_stall), .flush(flush), .clr_cnt(clr_cnt),
        .stall_id(st_o[0]), .bubble_ex(bb_o[0]), .fwd_sel(fw_o[0]),
        .stall_cnt(sc_o[0]), .fwd_cnt(fc_o[0])
    );

    hazard_forward_ctrl #(.REG_ADDR_W(4), .NUM_SRC(2), .CNT_W(4), .ZERO_REG_EN(1'b0)) dut_z (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src({s1, s0}),
        .id_src_used(id_used), .id_dst(id_dst), .id_reg_write(id_rw), .id_is_load(id_ld),
        .ext_stall(ext_stall), .flush(flush), .clr_cnt(clr_cnt),
        .stall_id(st_o[1]), .bubble_ex(bb_o[1]), .fwd_sel(fw_o[1]),
        .stall_cnt(sc_o[1]), .fwd_cnt(fc_o[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        bit       v;
        bit [3:0] dst;
        bit       rw;
        bit       ld;
        bit [3:0] src1;
        bit [3:0] src0;
        bit [1:0] used;
    } mtag_t;

    typedef struct packed {
        bit       st;
        bit       bb;
        bit [3:0] fw;
        bit [3:0] sc;
        bit [3:0] fc;
    } exp_t;

    mtag_t m_ex [2];
    mtag_t m_mem[2];
    mtag_t m_wb [2];
    bit [3:0] m_sc[2];
    bit [3:0] m_fc[2];
    bit zen[2] = '{1'b1, 1'b0};
    exp_t exp_q[$];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_wc(mtag_t t, bit z);
        return t.v && t.rw && !(z && t.dst == 4'd0);
    endfunction

    function automatic bit m_stall(int k);
        bit hit;
        hit = 1'b0;
        if (m_wc(m_ex[k], zen[k]) && m_ex[k].ld) begin
            if (id_used[0] && m_ex[k].dst == s0) hit = 1'b1;
            if (id_used[1] && m_ex[k].dst == s1) hit = 1'b1;
        end
        return !flush && id_valid && hit;
    endfunction

    function automatic bit [1:0] m_sel(int k, bit u, bit [3:0] s);
        if (!m_ex[k].v || !u) return 2'b00;
        if (m_wc(m_mem[k], zen[k]) && m_mem[k].dst == s) return 2'b10;
        if (m_wc(m_wb[k], zen[k]) && m_wb[k].dst == s) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit [3:0] m_fwd(int k);
        return {m_sel(k, m_ex[k].used[1], m_ex[k].src1), m_sel(k, m_ex[k].used[0], m_ex[k].src0)};
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0;
            m_sc[k] = '0; m_fc[k] = '0;
        end
    endtask

    // Clock-edge update of the model, using the inputs held across the edge
    task automatic m_edge();
        for (int k = 0; k < 2; k++) begin
            bit       st;
            bit [3:0] fw;
            st = m_stall(k);
            fw = m_fwd(k);
            if (clr_cnt) begin
                m_sc[k] = '0;
                m_fc[k] = '0;
            end else begin
                if (st && !ext_stall && m_sc[k] != 4'hf) m_sc[k]++;
                if (!ext_stall && m_ex[k].v && fw != 4'd0 && m_fc[k] != 4'hf) m_fc[k]++;
            end
            if (!ext_stall) begin
                m_wb[k]  = m_mem[k];
                m_mem[k] = m_ex[k];
                if (id_valid && !st && !flush)
                    m_ex[k] = '{v: 1'b1, dst: id_dst, rw: id_rw, ld: id_ld,
                                src1: s1, src0: s0, used: id_used};
                else
                    m_ex[k] = '0;
            end
        end
    endtask

    task automatic set_id(bit v, bit [3:0] a0, bit [3:0] a1, bit [1:0] u,
                          bit [3:0] d, bit w, bit l);
        id_valid = v; s0 = a0; s1 = a1; id_used = u; id_dst = d; id_rw = w; id_ld = l;
    endtask

    task automatic nop();
        set_id(1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0);
    endtask

    // Called just after a falling edge with inputs applied
    task automatic drive_chk();
        exp_t e;
        #1;
        for (int k = 0; k < 2; k++) begin
            e.st = m_stall(k);
            e.bb = m_stall(k) || flush;
            e.fw = m_fwd(k);
            e.sc = m_sc[k];
            e.fc = m_fc[k];
            exp_q.push_back(e);
        end
        for (int k = 0; k < 2; k++) begin
            e = exp_q.pop_front();
            chk($sformatf("sb_stall_id%0d", k), 32'(st_o[k]), 32'(e.st));
            chk($sformatf("sb_bubble_ex%0d", k), 32'(bb_o[k]), 32'(e.bb));
            chk($sformatf("sb_fwd_sel%0d", k), 32'(fw_o[k]), 32'(e.fw));
            chk($sformatf("sb_stall_cnt%0d", k), 32'(sc_o[k]), 32'(e.sc));
            chk($sformatf("sb_fwd_cnt%0d", k), 32'(fc_o[k]), 32'(e.fc));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m_edge();
        @(negedge clk);
    endtask

    task automatic step();
        drive_chk();
        tick();
    endtask

    task automatic chk_all_zero(string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_stall%0d", tag, k), 32'(st_o[k]), 32'd0);
            chk($sformatf("%s_bubble%0d", tag, k), 32'(bb_o[k]), 32'd0);
            chk($sformatf("%s_fwd%0d", tag, k), 32'(fw_o[k]), 32'd0);
            chk($sformatf("%s_scnt%0d", tag, k), 32'(sc_o[k]), 32'd0);
            chk($sformatf("%s_fcnt%0d", tag, k), 32'(fc_o[k]), 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ext_stall = 1'b0; flush = 1'b0; clr_cnt = 1'b0;
        nop();
        m_reset();
        #2;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // EX/MEM forward, then MEM/WB forward across a NOP
        set_id(1, 4'd0, 4'd0, 2'b00, 4'd3, 1, 0); step();
        set_id(1, 4'd3, 4'd0, 2'b01, 4'd8, 1, 0); step();
        nop(); drive_chk();
        chk("fwd_exmem", 32'(fw_o[0][1:0]), 32'd2);
        tick();
        chk("fwd_cnt_1", 32'(fc_o[0]), 32'd1);
        set_id(1, 4'd0, 4'd0, 2'b00, 4'd3, 1, 0); step();
        nop(); step();
        set_id(1, 4'd3, 4'd0, 2'b01, 4'd9, 1, 0); step();
        nop(); drive_chk();
        chk("fwd_memwb", 32'(fw_o[0][1:0]), 32'd1);
        tick();
        chk("fwd_cnt_2", 32'(fc_o[0]), 32'd2);

        // Same destination in MEM and WB: MEM wins
        set_id(1, 4'd0, 4'd0, 2'b00, 4'd5, 1, 0); step();
        set_id(1, 4'd0, 4'd0, 2'b00, 4'd5, 1, 0); step();
        set_id(1, 4'd5, 4'd0, 2'b01, 4'd10, 1, 0); step();
        nop(); drive_chk();
        chk("fwd_priority", 32'(fw_o[0][1:0]), 32'd2);
        tick();

        // Load-use: one stall, then MEM/WB forward of the loaded value
        set_id(1, 4'd0, 4'd0, 2'b00, 4'd2, 1, 1); step();
        set_id(1, 4'd2, 4'd1, 2'b11, 4'd4, 1, 0); drive_chk();
        chk("lu_stall", 32'(st_o[0]), 32'd1);
        chk("lu_bubble", 32'(bb_o[0]), 32'd1);
        tick();
        drive_chk();
        chk("lu_release", 32'(st_o[0]), 32'd0);
        chk("lu_stall_cnt", 32'(sc_o[0]), 32'd1);
        tick();
        nop(); drive_chk();
        chk("lu_fwd", 32'(fw_o[0]), 32'd1);
        tick();

        // Writes to r0: hardwired instance never forwards, the other does
        set_id(1, 4'd0, 4'd0, 2'b00, 4'd0, 1, 0); step();
        set_id(1, 4'd0, 4'd0, 2'b01, 4'd11, 1, 0); step();
        nop(); drive_chk();
        chk("r0_zero_en", 32'(fw_o[0]), 32'd0);
        chk("r0_no_zero", 32'(fw_o[1][1:0]), 32'd2);
        tick();

        // ext_stall held during a forward
        set_id(1, 4'd0, 4'd0, 2'b00, 4'd6, 1, 0); step();
        set_id(1, 4'd0, 4'd6, 2'b10, 4'd12, 1, 0); step();
        nop();
        ext_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive_chk();
            chk("frz_fwd", 32'(fw_o[0]), 32'h8);
            chk("frz_fcnt", 32'(fc_o[0]), 32'd4);
            tick();
        end
        ext_stall = 1'b0;
        step();
        chk("frz_fcnt_after", 32'(fc_o[0]), 32'd5);

        // flush coincident with a load-use hit
        set_id(1, 4'd0, 4'd0, 2'b00, 4'd7, 1, 1); step();
        set_id(1, 4'd7, 4'd0, 2'b01, 4'd13, 1, 0);
        flush = 1'b1;
        drive_chk();
        chk("flush_stall", 32'(st_o[0]), 32'd0);
        chk("flush_bubble", 32'(bb_o[0]), 32'd1);
        tick();
        flush = 1'b0;
        nop(); step();

        // Drive counters into saturation
        for (int n = 0; n < 20; n++) begin
            set_id(1, 4'd0, 4'd0, 2'b00, 4'd2, 1, 1); step();
            set_id(1, 4'd2, 4'd0, 2'b01, 4'd4, 1, 0); step();
            step();
        end
        nop(); drive_chk();
        chk("sat_stall_cnt", 32'(sc_o[0]), 32'd15);
        chk("sat_fwd_cnt", 32'(fc_o[0]), 32'd15);
        tick();

        // clr_cnt alongside a stall
        set_id(1, 4'd0, 4'd0, 2'b00, 4'd2, 1, 1); step();
        set_id(1, 4'd2, 4'd0, 2'b01, 4'd4, 1, 0);
        clr_cnt = 1'b1;
        drive_chk();
        chk("clr_with_stall", 32'(st_o[0]), 32'd1);
        tick();
        clr_cnt = 1'b0;
        drive_chk();
        chk("clr_stall_cnt", 32'(sc_o[0]), 32'd0);
        tick();

        // Random traffic on a small register set to force collisions
        for (int n = 0; n < 400; n++) begin
            set_id($urandom_range(0, 3) != 0, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
            ext_stall = ($urandom_range(0, 4) == 0);
            flush     = ($urandom_range(0, 7) == 0);
            clr_cnt   = ($urandom_range(0, 39) == 0);
            step();
        end
        ext_stall = 1'b0; flush = 1'b0; clr_cnt = 1'b0;

        // Reset pulse with a forward in flight
        set_id(1, 4'd0, 4'd0, 2'b00, 4'd9, 1, 0); step();
        set_id(1, 4'd9, 4'd0, 2'b01, 4'd14, 1, 0); step();
        nop(); drive_chk();
        chk("pre_rst_fwd", 32'(fw_o[0][1:0]), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        @(negedge clk);
        m_reset();
        rst_n = 1'b1;
        set_id(1, 4'd9, 4'd0, 2'b01, 4'd1, 1, 0); drive_chk();
        chk("post_rst_fwd", 32'(fw_o[0]), 32'd0);
        tick();
        nop();
        for (int n = 0; n < 4; n++) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
